// File: rtl/sys_ctrl_pkg.sv
// Shared system-controller definitions: command codes, RX FSM state
// encoding and the fixed register-file slots used for ALU operands.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_OP_A,
      ST_OP_B,
      ST_ALU_FUN
   } rx_state_e;

endpackage

// File: rtl/sys_ctrl_rx_if.sv
// Byte stream in, register-file / ALU strobes out.
// master = byte source / strobe consumer; slave = the decoder.
interface sys_ctrl_rx_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rf_wr_en;
   logic                  rf_rd_en;
   logic [ADDR_WIDTH-1:0] rf_addr;
   logic [DATA_WIDTH-1:0] rf_wr_data;
   logic                  alu_en;
   logic [3:0]            alu_fun;
   logic                  cmd_err;

   modport master (
      output rx_data, rx_valid,
      input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, cmd_err
   );

   modport slave (
      input  rx_data, rx_valid,
      output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, cmd_err
   );
endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer. expired is raised combinationally during the
// cycle whose closing edge would be the GAP_CYCLES-th idle edge after the
// last clear, so the consumer's registered response lands exactly
// GAP_CYCLES cycles after the last byte.
module rx_gap_timer #(
   parameter int GAP_CYCLES = 4096
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic run,
   output logic expired
);
   localparam int CW = $clog2(GAP_CYCLES + 1);

   logic [CW-1:0] cnt;

   assign expired = run && (cnt == CW'(GAP_CYCLES - 1));

   // count idle cycles inside a frame; any byte or leaving the frame restarts
   always_ff @(posedge CLK) begin
      if (RST || clear || !run)
         cnt <= '0;
      else if (!expired)
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/sys_ctrl_rx.sv
// RX command decoder: parses AA/BB/CC/DD frames from the synchronized
// byte stream into single-cycle register-file and ALU strobes.
// Optional inter-byte timeout: define SYS_CTRL_RX_TIMEOUT_EN.
module sys_ctrl_rx
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int GAP_CYCLES = 4096
) (
   input  logic         CLK,
   input  logic         RST,
   sys_ctrl_rx_if.slave bus
);
   rx_state_e             state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_en_q, rd_en_q, alu_en_q, err_q;
   logic [ADDR_WIDTH-1:0] rf_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [3:0]            alu_fun_q;
   logic                  timeout;

`ifdef SYS_CTRL_RX_TIMEOUT_EN
   rx_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
      .CLK     (CLK),
      .RST     (RST),
      .clear   (bus.rx_valid),
      .run     (state != ST_IDLE),
      .expired (timeout)
   );
`else
   // no timer: a partial frame waits forever (GAP_CYCLES kept referenced so
   // both builds share one parameter list)
   assign timeout = (GAP_CYCLES < 0);
`endif

   assign bus.rf_wr_en   = wr_en_q;
   assign bus.rf_rd_en   = rd_en_q;
   assign bus.alu_en     = alu_en_q;
   assign bus.cmd_err    = err_q;
   assign bus.rf_addr    = rf_addr_q;
   assign bus.rf_wr_data = wr_data_q;
   assign bus.alu_fun    = alu_fun_q;

   // frame FSM with registered strobes; a byte always beats a timeout
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         err_q     <= 1'b0;
         rf_addr_q <= '0;
         wr_data_q <= '0;
         alu_fun_q <= '0;
      end else begin
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         alu_en_q <= 1'b0;
         err_q    <= 1'b0;
         if (bus.rx_valid) begin
            case (state)
               ST_IDLE: begin
                  case (bus.rx_data)
                     DATA_WIDTH'(CMD_WR):      state <= ST_WR_ADDR;
                     DATA_WIDTH'(CMD_RD):      state <= ST_RD_ADDR;
                     DATA_WIDTH'(CMD_ALU_OP):  state <= ST_OP_A;
                     DATA_WIDTH'(CMD_ALU_NOP): state <= ST_ALU_FUN;
                     default:                  err_q <= 1'b1;
                  endcase
               end
               ST_WR_ADDR: begin
                  addr_q <= bus.rx_data[ADDR_WIDTH-1:0];
                  state  <= ST_WR_DATA;
               end
               ST_WR_DATA: begin
                  wr_en_q   <= 1'b1;
                  rf_addr_q <= addr_q;
                  wr_data_q <= bus.rx_data;
                  state     <= ST_IDLE;
               end
               ST_RD_ADDR: begin
                  rd_en_q   <= 1'b1;
                  rf_addr_q <= bus.rx_data[ADDR_WIDTH-1:0];
                  state     <= ST_IDLE;
               end
               ST_OP_A: begin
                  wr_en_q   <= 1'b1;
                  rf_addr_q <= ADDR_WIDTH'(OPA_ADDR);
                  wr_data_q <= bus.rx_data;
                  state     <= ST_OP_B;
               end
               ST_OP_B: begin
                  wr_en_q   <= 1'b1;
                  rf_addr_q <= ADDR_WIDTH'(OPB_ADDR);
                  wr_data_q <= bus.rx_data;
                  state     <= ST_ALU_FUN;
               end
               ST_ALU_FUN: begin
                  alu_en_q  <= 1'b1;
                  alu_fun_q <= bus.rx_data[3:0];
                  state     <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (timeout) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
         end
      end
   end
endmodule

// File: doc/sys_ctrl_rx.md
# sys_ctrl_rx

Receive-side command decoder of the system controller. It sits directly downstream of the RX bus synchronizer and consumes its synchronized byte bus and one-cycle enable pulse. It parses framed UART commands and issues single-cycle register-file write/read strobes and ALU start strobes. Frames are register write, register read, ALU operation with operands, and ALU operation without operands.

## Interface
Parameters:
- DATA_WIDTH, 8, width of received byte and register data
- ADDR_WIDTH, 4, register-file address width
- GAP_CYCLES, 4096, maximum inter-byte gap in CLK cycles; used only when the timeout feature is compiled in

Ports:
- CLK  in  1  single clock
- RST  in  1  synchronous, active-high reset
- rx_data  in  DATA_WIDTH  synchronized received byte
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle
- rf_wr_en  out  1  one-cycle register write strobe
- rf_rd_en  out  1  one-cycle register read strobe
- rf_addr  out  ADDR_WIDTH  register address for the current strobe
- rf_wr_data  out  DATA_WIDTH  write data, valid with rf_wr_en
- alu_en  out  1  one-cycle ALU start strobe
- alu_fun  out  4  ALU function code, valid with alu_en
- cmd_err  out  1  one-cycle pulse: unknown command byte, or aborted frame

## Operation
- Command codes:
  - 0xAA: write, frame AA, addr, data
  - 0xBB: read, frame BB, addr
  - 0xCC: ALU with operands, frame CC, A, B, fun
  - 0xDD: ALU without operands, frame DD, fun
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN.
- All transitions occur only in a cycle with rx_valid=1; without rx_valid the state holds.
- Transitions from IDLE:
  - AA → WR_ADDR; BB → RD_ADDR; CC → OP_A; DD → ALU_FUN.
  - Any other byte → stay in IDLE and pulse cmd_err.
- WR_ADDR: capture rx_data[ADDR_WIDTH-1:0] into the address register → WR_DATA.
- WR_DATA: pulse rf_wr_en with the captured address and rf_wr_data=rx_data → IDLE.
- RD_ADDR: pulse rf_rd_en with rf_addr=rx_data[ADDR_WIDTH-1:0] → IDLE.
- OP_A: pulse rf_wr_en, rf_addr=0, rf_wr_data=rx_data → OP_B.
- OP_B: pulse rf_wr_en, rf_addr=1, rf_wr_data=rx_data → ALU_FUN.
- ALU_FUN: pulse alu_en, alu_fun=rx_data[3:0] → IDLE.
- Address bytes: upper bits above ADDR_WIDTH are ignored; no error is raised.
- Payload bytes are never decoded as commands. A data byte of 0xAA inside a frame is data.
- Strobes are mutually exclusive; at most one of rf_wr_en, rf_rd_en, alu_en, cmd_err is high per cycle.

## Timing
- All outputs are registered.
- Each strobe rises in the cycle after the rx_valid that completes its field and lasts exactly one cycle.
- rf_addr, rf_wr_data and alu_fun hold their last value between strobes.
- Reset values: state IDLE; rf_wr_en, rf_rd_en, alu_en, cmd_err = 0; rf_addr = 0; rf_wr_data = 0; alu_fun = 0.
- RST asserted mid-frame: next cycle is IDLE with all strobes low. The partial frame is discarded and no cmd_err is raised.
- Back-to-back rx_valid pulses on consecutive cycles are accepted. There is no backpressure, and every pulse is consumed.
- Minimum frame-to-frame spacing: none. A new command byte may arrive in the cycle immediately after the last byte of the previous frame.

## Configuration
- SYS_CTRL_RX_TIMEOUT_EN defined:
  - A gap counter is cleared on every rx_valid and increments while state ≠ IDLE.
  - When it reaches GAP_CYCLES, the FSM returns to IDLE and pulses cmd_err once.
  - If rx_valid arrives in the same cycle the count reaches GAP_CYCLES, the byte wins and no timeout is raised.
- Undefined: no counter. A partial frame waits indefinitely, and GAP_CYCLES is unused.

## Structure
- Shared package sys_ctrl_pkg: command-code constants (CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP), FSM state encoding, and OPA_ADDR=0 / OPB_ADDR=1. The TX-side controller reuses these.
- Optional sub-module rx_gap_timer, instantiated only under SYS_CTRL_RX_TIMEOUT_EN. Ports: CLK, RST, clear, run, expired.

## Test plan
- AA,05,3C on rx_valid pulses → one rf_wr_en with rf_addr=5, rf_wr_data=0x3C, one cycle after the third pulse; no other strobes.
- BB,0A → one rf_rd_en with rf_addr=0xA; rf_wr_en never asserted.
- CC,11,22,03 on back-to-back cycles → rf_wr_en addr0/0x11, then addr1/0x22, then alu_en with alu_fun=3, on three consecutive cycles.
- DD,0E, then byte 7F → alu_en with alu_fun=0xE; then cmd_err pulse for 7F with state remaining IDLE.
- AA,02 then RST for one cycle, then AA,02,55 → only one write, addr2/0x55; no cmd_err.
- With SYS_CTRL_RX_TIMEOUT_EN and GAP_CYCLES=16: CC,01, then silence → cmd_err exactly 16 cycles after the last pulse. A following DD,04 then yields alu_en with fun=4.
